mem_arbiter: RTL

- Arbitrates the single shared system RAM port (dpram/SDRAM byte port) between three requesters: ROM/PRG downloader, RAM eraser and VTL chip (CPU + video fetch).
- Fixed priority with anti-starvation promotion for the VTL chip.
- Each requester uses a req/ack/rvalid handshake; the arbiter sequences issue, read latency and data return.
- Sits between the downloader/eraser/VTL_chip and the RAM.

---
 rtl/mem_arbiter.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Shared RAM port arbiter for the downloader, RAM eraser and VTL chip.
// Fixed priority dl > er > vdc, with vdc promoted once it has waited STARVE_LIMIT cycles.
module mem_arbiter #(
    parameter int RD_LATENCY   = 1,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        F14Mx2,
    input  logic        reset_n,
    input  logic        dl_req,
    input  logic        er_req,
    input  logic        vdc_req,
    input  logic        dl_we,
    input  logic        er_we,
    input  logic        vdc_we,
    input  logic [24:0] dl_addr,
    input  logic [24:0] er_addr,
    input  logic [24:0] vdc_addr,
    input  logic [7:0]  dl_wdata,
    input  logic [7:0]  er_wdata,
    input  logic [7:0]  vdc_wdata,
    output logic        dl_ack,
    output logic        er_ack,
    output logic        vdc_ack,
    output logic [7:0]  dl_rdata,
    output logic [7:0]  er_rdata,
    output logic [7:0]  vdc_rdata,
    output logic        dl_rvalid,
    output logic        er_rvalid,
    output logic        vdc_rvalid,
    output logic [24:0] mem_addr,
    output logic [7:0]  mem_din,
    output logic        mem_wr,
    output logic        mem_rd,
    input  logic [7:0]  mem_dout,
    output logic        busy
);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

    localparam logic [1:0] OWN_DL     = 2'd0;
    localparam logic [1:0] OWN_ER     = 2'd1;
    localparam logic [1:0] OWN_VDC    = 2'd2;
    localparam logic [3:0] LAT_LOAD   = 4'(RD_LATENCY - 1);
    localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

    state_t      state_q, state_d;
    logic [1:0]  owner_q, owner_d;
    logic [24:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [3:0]  lat_q, lat_d;
    logic [7:0]  starve_q, starve_d;
    logic [7:0]  rdata_q [3];
    logic [7:0]  rdata_d [3];
    logic [2:0]  rvalid_q, rvalid_d;

    logic [2:0]  req_v;
    logic [2:0]  we_v;
    logic [24:0] addr_v  [3];
    logic [7:0]  wdata_v [3];
    logic [2:0]  ack;
    logic        starved;
    logic        vdc_holds;
    logic        win;
    logic [1:0]  win_id;

    assign req_v   = {vdc_req, er_req, dl_req};
    assign we_v    = {vdc_we, er_we, dl_we};
    assign addr_v  = '{dl_addr, er_addr, vdc_addr};
    assign wdata_v = '{dl_wdata, er_wdata, vdc_wdata};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_ack
            assign ack[gi] = (state_q == ST_ISSUE) && (owner_q == 2'(gi));
        end
    endgenerate

    assign starved   = (starve_q == STARVE_MAX);
    assign vdc_holds = (state_q != ST_IDLE) && (owner_q == OWN_VDC);

    // A starved vdc pre-empts the fixed order, but only at this IDLE decision point.
    always_comb begin
        win    = 1'b1;
        win_id = OWN_DL;
        if (starved && vdc_req) win_id = OWN_VDC;
        else if (dl_req)        win_id = OWN_DL;
        else if (er_req)        win_id = OWN_ER;
        else if (vdc_req)       win_id = OWN_VDC;
        else                    win    = 1'b0;
    end

    always_comb begin
        starve_d = starve_q;
        if (!vdc_req || ack[2])
            starve_d = '0;
        else if (!vdc_holds && !starved)
            starve_d = starve_q + 8'd1;
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        addr_d   = addr_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        lat_d    = lat_q;
        rvalid_d = '0;
        for (int i = 0; i < 3; i++) rdata_d[i] = rdata_q[i];
        case (state_q)
            ST_IDLE: begin
                if (win) begin
                    owner_d = win_id;
                    state_d = ST_ISSUE;
                    for (int i = 0; i < 3; i++) begin
                        if (win_id == 2'(i)) begin
                            addr_d  = addr_v[i];
                            we_d    = we_v[i];
                            wdata_d = wdata_v[i];
                        end
                    end
                end
            end
            ST_ISSUE: begin
                if (we_q) begin
                    state_d = ST_IDLE;
                end else begin
                    lat_d   = LAT_LOAD;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (lat_q == '0) begin
                    for (int i = 0; i < 3; i++) begin
                        if (owner_q == 2'(i)) begin
                            rdata_d[i]  = mem_dout;
                            rvalid_d[i] = 1'b1;
                        end
                    end
                    state_d = ST_IDLE;
                end else begin
                    lat_d = lat_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge F14Mx2 or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            owner_q  <= OWN_DL;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            lat_q    <= '0;
            starve_q <= '0;
            rvalid_q <= '0;
            for (int i = 0; i < 3; i++) rdata_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            lat_q    <= lat_d;
            starve_q <= starve_d;
            rvalid_q <= rvalid_d;
            for (int i = 0; i < 3; i++) rdata_q[i] <= rdata_d[i];
        end
    end

    assign mem_addr   = addr_q;
    assign mem_din    = wdata_q;
    assign mem_wr     = (state_q == ST_ISSUE) && we_q;
    assign mem_rd     = (state_q == ST_ISSUE) && !we_q;
    assign busy       = (state_q != ST_IDLE);
    assign dl_ack     = ack[0];
    assign er_ack     = ack[1];
    assign vdc_ack    = ack[2];
    assign dl_rdata   = rdata_q[0];
    assign er_rdata   = rdata_q[1];
    assign vdc_rdata  = rdata_q[2];
    assign dl_rvalid  = rvalid_q[0];
    assign er_rvalid  = rvalid_q[1];
    assign vdc_rvalid = rvalid_q[2];

endmodule
